// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide, one-cycle-latency memory port between the
// instruction fetch unit and the load/store unit. Requests are served one
// byte per cycle; loads and fetches assemble a little-endian word, stores
// emit the low bytes of the store data.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsu_req,
    input  logic              lsu_wr,
    input  logic [1:0]        lsu_len,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Number of bytes moved for an LSU length code.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'b00:   len_bytes = 3'd1;
            2'b01:   len_bytes = 3'd2;
            default: len_bytes = 3'd4;
        endcase
    endfunction

    // Byte lane idx of a little-endian word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_of = w[7:0];
            2'd1:    byte_of = w[15:8];
            2'd2:    byte_of = w[23:16];
            2'd3:    byte_of = w[31:24];
            default: byte_of = 8'h00;
        endcase
    endfunction

    // Base plus byte offset; wraps naturally at the address width.
    function automatic logic [ADDR_W-1:0] addr_off(input logic [ADDR_W-1:0] base,
                                                   input logic [2:0] idx);
        addr_off = base + {{(ADDR_W-3){1'b0}}, idx};
    endfunction

    state_t            state_r;
    logic              owner_lsu_r;   // 1 = LSU owns the transaction, 0 = fetch
    logic [ADDR_W-1:0] base_r;
    logic [2:0]        n_r;           // bytes in this transaction
    logic [31:0]       wdata_r;
    logic [2:0]        cnt_r;         // bytes captured (read) or written (write)
    logic              pend_r;        // mem_a of the previous cycle was a real read
    logic [31:0]       rbuf_r;
    logic              if_done_r;
    logic              lsu_done_r;
    logic              mem_wr_r;
    logic [ADDR_W-1:0] mem_a_r;
    logic [7:0]        mem_dout_r;
    logic [31:0]       if_data_r;
    logic [31:0]       lsu_rdata_r;

    logic [31:0]       cap_word_s;
    logic [2:0]        cur_idx_s;
    logic [2:0]        nxt_idx_s;
    logic [2:0]        wnxt_idx_s;
    logic              last_cap_s;
    logic              done_pend_s;

    // Byte index currently on mem_a, the one after it, and the next store byte.
    assign cur_idx_s   = cnt_r + {2'b00, pend_r};
    assign nxt_idx_s   = cur_idx_s + 3'd1;
    assign wnxt_idx_s  = cnt_r + 3'd1;
    assign last_cap_s  = pend_r & (cnt_r == (n_r - 3'd1));
    assign done_pend_s = if_done_r | lsu_done_r;

    // Write strobe and done pulses are masked while the debug host owns the bus.
    assign mem_wr    = mem_wr_r & rdy_in;
    assign if_done   = if_done_r & rdy_in;
    assign lsu_done  = lsu_done_r & rdy_in;
    assign mem_a     = mem_a_r;
    assign mem_dout  = mem_dout_r;
    assign if_data   = if_data_r;
    assign lsu_rdata = lsu_rdata_r;

    // Merge the incoming memory byte into its lane of the assembly buffer.
    always_comb begin
        cap_word_s = rbuf_r;
        case (cnt_r[1:0])
            2'd0:    cap_word_s[7:0]   = mem_din;
            2'd1:    cap_word_s[15:8]  = mem_din;
            2'd2:    cap_word_s[23:16] = mem_din;
            2'd3:    cap_word_s[31:24] = mem_din;
            default: cap_word_s        = rbuf_r;
        endcase
    end

    // Arbitration, byte sequencing, stall/flush handling and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r     <= IDLE;
            owner_lsu_r <= 1'b0;
            base_r      <= {ADDR_W{1'b0}};
            n_r         <= 3'd0;
            wdata_r     <= 32'h0000_0000;
            cnt_r       <= 3'd0;
            pend_r      <= 1'b0;
            rbuf_r      <= 32'h0000_0000;
            if_done_r   <= 1'b0;
            lsu_done_r  <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_a_r     <= {ADDR_W{1'b0}};
            mem_dout_r  <= 8'h00;
            if_data_r   <= 32'h0000_0000;
            lsu_rdata_r <= 32'h0000_0000;
        end else if (!rdy_in) begin
            // Stalled: counters frozen. A read restarts from the oldest
            // uncaptured byte, whose data in the resume cycle is not valid yet.
            if (state_r == READ) begin
                mem_a_r <= addr_off(base_r, cnt_r);
                pend_r  <= 1'b0;
            end else begin
                pend_r  <= pend_r;
            end
        end else begin
            if_done_r  <= 1'b0;
            lsu_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // No new grant while a done pulse is on the outputs.
                    if (!done_pend_s) begin
                        if (lsu_req) begin
                            owner_lsu_r <= 1'b1;
                            base_r      <= lsu_addr;
                            n_r         <= len_bytes(lsu_len);
                            wdata_r     <= lsu_wdata;
                            cnt_r       <= 3'd0;
                            pend_r      <= 1'b0;
                            rbuf_r      <= 32'h0000_0000;
                            mem_a_r     <= lsu_addr;
                            if (lsu_wr) begin
                                state_r    <= WRITE;
                                mem_wr_r   <= 1'b1;
                                mem_dout_r <= lsu_wdata[7:0];
                            end else begin
                                state_r    <= READ;
                            end
                        end else if (if_req && !flush_in) begin
                            owner_lsu_r <= 1'b0;
                            base_r      <= if_addr;
                            n_r         <= 3'd4;
                            cnt_r       <= 3'd0;
                            pend_r      <= 1'b0;
                            rbuf_r      <= 32'h0000_0000;
                            mem_a_r     <= if_addr;
                            state_r     <= READ;
                        end else begin
                            state_r     <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (flush_in && !owner_lsu_r) begin
                        // Abandon the fetch silently; if_data keeps its old value.
                        state_r <= IDLE;
                        mem_a_r <= {ADDR_W{1'b0}};
                        pend_r  <= 1'b0;
                        cnt_r   <= 3'd0;
                    end else if (last_cap_s) begin
                        state_r <= IDLE;
                        mem_a_r <= {ADDR_W{1'b0}};
                        pend_r  <= 1'b0;
                        cnt_r   <= 3'd0;
                        rbuf_r  <= cap_word_s;
                        if (owner_lsu_r) begin
                            lsu_rdata_r <= cap_word_s;
                            lsu_done_r  <= 1'b1;
                        end else begin
                            if_data_r   <= cap_word_s;
                            if_done_r   <= 1'b1;
                        end
                    end else begin
                        if (pend_r) begin
                            rbuf_r <= cap_word_s;
                            cnt_r  <= cnt_r + 3'd1;
                        end else begin
                            cnt_r  <= cnt_r;
                        end
                        pend_r  <= (cur_idx_s < n_r);
                        mem_a_r <= (nxt_idx_s < n_r) ? addr_off(base_r, nxt_idx_s)
                                                     : {ADDR_W{1'b0}};
                    end
                end
                WRITE: begin
                    if (wnxt_idx_s == n_r) begin
                        state_r    <= IDLE;
                        mem_wr_r   <= 1'b0;
                        mem_a_r    <= {ADDR_W{1'b0}};
                        mem_dout_r <= 8'h00;
                        cnt_r      <= 3'd0;
                        lsu_done_r <= 1'b1;
                    end else begin
                        cnt_r      <= wnxt_idx_s;
                        mem_a_r    <= addr_off(base_r, wnxt_idx_s);
                        mem_dout_r <= byte_of(wdata_r, wnxt_idx_s[1:0]);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    mem_wr_r   <= 1'b0;
                    mem_a_r    <= {ADDR_W{1'b0}};
                    mem_dout_r <= 8'h00;
                    cnt_r      <= 3'd0;
                    pend_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a one-cycle-latency byte memory model.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in, flush_in;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        lsu_req, lsu_wr, lsu_done;
    logic [1:0]  lsu_len;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [7:0] mem [0:65535];

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_len(lsu_len), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    // Memory model: read data one cycle after the address, writes on the edge.
    always @(posedge clk_in) begin
        mem_din <= mem[mem_a[15:0]];
        if (mem_wr === 1'b1) begin
            mem[mem_a[15:0]] = mem_dout;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic drive_idle();
        rdy_in = 1'b1; flush_in = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        lsu_req = 1'b0; lsu_wr = 1'b0; lsu_len = 2'b00;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        #1;
        checks++;
        if ({if_done, lsu_done, mem_wr} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl: got %b want 000", {if_done, lsu_done, mem_wr});
        end
        checks++;
        if (mem_a !== 32'h0 || mem_dout !== 8'h00) begin
            errors++; $display("FAIL reset_bus: got a=%h d=%h want 0", mem_a, mem_dout);
        end
        checks++;
        if (if_data !== 32'h0 || lsu_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h %h want 0", if_data, lsu_rdata);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_fetch();
        logic [31:0] exp_a;
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_in);
            if (k == 7) if_req = 1'b0;
            #1;
            exp_a = (k <= 4) ? (32'h100 + 32'(k - 1)) : 32'h0;
            checks++;
            if (mem_a !== exp_a) begin
                errors++; $display("FAIL fetch_addr c%0d: got %h want %h", k, mem_a, exp_a);
            end
            checks++;
            if (if_done !== (k == 6)) begin
                errors++; $display("FAIL fetch_done c%0d: got %b want %b", k, if_done, (k == 6));
            end
        end
        checks++;
        if (if_data !== 32'h0000_0513) begin
            errors++; $display("FAIL fetch_data: got %h want 00000513", if_data);
        end
    endtask

    task automatic test_priority();
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h300;
        lsu_req = 1'b1; lsu_wr = 1'b0; lsu_len = 2'b00; lsu_addr = 32'h2004;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk_in);
            if (k == 4) lsu_req = 1'b0;
            if (k == 11) if_req = 1'b0;
            #1;
            if (k == 1 || k == 5) begin
                checks++;
                if (mem_a !== ((k == 1) ? 32'h2004 : 32'h300)) begin
                    errors++; $display("FAIL prio_addr c%0d: got %h", k, mem_a);
                end
            end
            checks++;
            if ({lsu_done, if_done} !== {(k == 3), (k == 10)}) begin
                errors++; $display("FAIL prio_done c%0d: got %b want %b", k,
                                   {lsu_done, if_done}, {(k == 3), (k == 10)});
            end
        end
        checks++;
        if (lsu_rdata !== 32'h0000_00FF || if_data !== 32'h4433_2211) begin
            errors++; $display("FAIL prio_data: got %h %h want 000000ff 44332211", lsu_rdata, if_data);
        end
    endtask

    task automatic test_store();
        int w0;
        w0 = wr_cnt;
        @(negedge clk_in);
        lsu_req = 1'b1; lsu_wr = 1'b1; lsu_len = 2'b01;
        lsu_addr = 32'h2000; lsu_wdata = 32'hA5A5_BEEF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            if (k == 4) lsu_req = 1'b0;
            #1;
            checks++;
            if (mem_wr !== (k <= 2) || lsu_done !== (k == 3)) begin
                errors++; $display("FAIL store_ctl c%0d: got wr=%b done=%b", k, mem_wr, lsu_done);
            end
            if (k <= 2) begin
                checks++;
                if ({mem_a, mem_dout} !== ((k == 1) ? {32'h2000, 8'hEF} : {32'h2001, 8'hBE})) begin
                    errors++; $display("FAIL store_bus c%0d: got %h %h", k, mem_a, mem_dout);
                end
            end
        end
        checks++;
        if (wr_cnt - w0 != 2 || mem[16'h2000] !== 8'hEF || mem[16'h2001] !== 8'hBE
            || mem[16'h2002] !== 8'h77) begin
            errors++; $display("FAIL store_mem: got n=%0d %h %h %h want 2 ef be 77", wr_cnt - w0,
                               mem[16'h2000], mem[16'h2001], mem[16'h2002]);
        end
        // Word load back, then a halfword load that must zero-extend.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk_in);
            lsu_req = 1'b1; lsu_wr = 1'b0;
            lsu_len = (t == 0) ? 2'b10 : 2'b01;
            lsu_addr = (t == 0) ? 32'h2000 : 32'h2002;
            for (int k = 1; k <= 7; k++) begin
                @(negedge clk_in);
                if (k == 7) lsu_req = 1'b0;
                #1;
                checks++;
                if (lsu_done !== (k == ((t == 0) ? 6 : 4))) begin
                    errors++; $display("FAIL load_done t%0d c%0d: got %b", t, k, lsu_done);
                end
            end
            checks++;
            if (lsu_rdata !== ((t == 0) ? 32'h6677_BEEF : 32'h0000_6677)) begin
                errors++; $display("FAIL load_data t%0d: got %h", t, lsu_rdata);
            end
        end
    endtask

    task automatic test_flush();
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_in);
            if (k == 3) flush_in = 1'b1;
            if (k == 4) begin flush_in = 1'b0; if_req = 1'b0; end
            #1;
            checks++;
            if (if_done !== 1'b0) begin
                errors++; $display("FAIL flush_done c%0d: got %b want 0", k, if_done);
            end
            if (k == 4) begin
                checks++;
                if (mem_a !== 32'h0) begin
                    errors++; $display("FAIL flush_addr: got %h want 0", mem_a);
                end
            end
        end
        checks++;
        if (if_data !== 32'h4433_2211) begin
            errors++; $display("FAIL flush_data: got %h want 44332211", if_data);
        end
        // Flush together with a fetch request in IDLE: fetch not accepted.
        @(negedge clk_in);
        if_req = 1'b1; flush_in = 1'b1; if_addr = 32'h100;
        @(negedge clk_in);
        if_req = 1'b0; flush_in = 1'b0;
        #1;
        checks++;
        if (mem_a !== 32'h0) begin
            errors++; $display("FAIL flush_idle: got %h want 0", mem_a);
        end
        // Flush during a load has no effect on it.
        @(negedge clk_in);
        lsu_req = 1'b1; lsu_wr = 1'b0; lsu_len = 2'b00; lsu_addr = 32'h2004;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            flush_in = (k <= 2);
            if (k == 4) lsu_req = 1'b0;
            #1;
            checks++;
            if (lsu_done !== (k == 3)) begin
                errors++; $display("FAIL flush_lsu c%0d: got %b", k, lsu_done);
            end
        end
        checks++;
        if (lsu_rdata !== 32'h0000_00FF) begin
            errors++; $display("FAIL flush_lsu_data: got %h want 000000ff", lsu_rdata);
        end
    endtask

    task automatic test_stall();
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h400;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk_in);
            if (k == 3) rdy_in = 1'b0;
            if (k == 6) rdy_in = 1'b1;
            if (k == 11) if_req = 1'b0;
            #1;
            checks++;
            if (if_done !== (k == 10) || mem_wr !== 1'b0) begin
                errors++; $display("FAIL stall_ctl c%0d: got done=%b wr=%b", k, if_done, mem_wr);
            end
            if (k == 6 || k == 7) begin
                checks++;
                if (mem_a !== ((k == 6) ? 32'h401 : 32'h402)) begin
                    errors++; $display("FAIL stall_addr c%0d: got %h", k, mem_a);
                end
            end
        end
        checks++;
        if (if_data !== 32'hEFBE_ADDE) begin
            errors++; $display("FAIL stall_data: got %h want efbeadde", if_data);
        end
    endtask

    task automatic test_write_stall();
        int w0;
        int idx;
        logic ew;
        w0 = wr_cnt;
        @(negedge clk_in);
        lsu_req = 1'b1; lsu_wr = 1'b1; lsu_len = 2'b10;
        lsu_addr = 32'h2100; lsu_wdata = 32'h4433_2211;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_in);
            rdy_in = (k != 2);
            if (k == 7) lsu_req = 1'b0;
            #1;
            ew = (k == 1) || (k >= 3 && k <= 5);
            idx = (k == 1) ? 0 : k - 2;
            checks++;
            if (mem_wr !== ew || lsu_done !== (k == 6)) begin
                errors++; $display("FAIL wstall_ctl c%0d: got wr=%b done=%b", k, mem_wr, lsu_done);
            end
            if (ew) begin
                checks++;
                if (mem_a !== 32'h2100 + 32'(idx) || mem_dout !== 8'(8'h11 * (idx + 1))) begin
                    errors++; $display("FAIL wstall_bus c%0d: got %h %h", k, mem_a, mem_dout);
                end
            end
        end
        checks++;
        if (wr_cnt - w0 != 4 || mem[16'h2101] !== 8'h22 || mem[16'h2103] !== 8'h44) begin
            errors++; $display("FAIL wstall_mem: got n=%0d %h %h want 4 22 44", wr_cnt - w0,
                               mem[16'h2101], mem[16'h2103]);
        end
        // A done pulse falling in a stall cycle appears one cycle later.
        @(negedge clk_in);
        lsu_req = 1'b1; lsu_wr = 1'b0; lsu_len = 2'b00; lsu_addr = 32'h2004;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_in);
            rdy_in = (k != 3);
            if (k == 5) lsu_req = 1'b0;
            #1;
            checks++;
            if (lsu_done !== (k == 4)) begin
                errors++; $display("FAIL defer_done c%0d: got %b want %b", k, lsu_done, (k == 4));
            end
        end
        checks++;
        if (mem_a !== 32'h0) begin
            errors++; $display("FAIL defer_idle: got %h want 0", mem_a);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_in);
        lsu_req = 1'b1; lsu_wr = 1'b1; lsu_len = 2'b10;
        lsu_addr = 32'h2200; lsu_wdata = 32'hCAFE_F00D;
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        checks++;
        if (mem_wr !== 1'b1) begin
            errors++; $display("FAIL rmid_pre: got wr=%b want 1", mem_wr);
        end
        #2;
        rst_in = 1'b1;
        lsu_req = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h00) begin
            errors++; $display("FAIL rmid_now: got wr=%b a=%h d=%h", mem_wr, mem_a, mem_dout);
        end
        for (int k = 3; k <= 7; k++) begin
            @(negedge clk_in);
            if (k == 3) rst_in = 1'b0;
            #1;
            checks++;
            if (lsu_done !== 1'b0 || mem_wr !== 1'b0) begin
                errors++; $display("FAIL rmid_quiet c%0d: got done=%b wr=%b", k, lsu_done, mem_wr);
            end
        end
        checks++;
        if (mem[16'h2200] !== 8'h0D || mem[16'h2201] !== 8'h00 || lsu_rdata !== 32'h0) begin
            errors++; $display("FAIL rmid_mem: got %h %h rdata=%h want 0d 00 0",
                               mem[16'h2200], mem[16'h2201], lsu_rdata);
        end
        @(negedge clk_in);
        lsu_req = 1'b1; lsu_wr = 1'b0; lsu_len = 2'b00; lsu_addr = 32'h2200;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            if (k == 4) lsu_req = 1'b0;
            #1;
            checks++;
            if (lsu_done !== (k == 3)) begin
                errors++; $display("FAIL rmid_load c%0d: got %b", k, lsu_done);
            end
        end
        checks++;
        if (lsu_rdata !== 32'h0000_000D) begin
            errors++; $display("FAIL rmid_data: got %h want 0000000d", lsu_rdata);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a;
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'hFFFF_FFFF;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_in);
            if (k == 7) if_req = 1'b0;
            #1;
            exp_a = (k >= 2 && k <= 4) ? 32'(k - 2) : ((k == 1) ? 32'hFFFF_FFFF : 32'h0);
            checks++;
            if (mem_a !== exp_a || if_done !== (k == 6)) begin
                errors++; $display("FAIL wrap c%0d: got a=%h done=%b want a=%h", k, mem_a, if_done, exp_a);
            end
        end
        checks++;
        if (if_data !== 32'h0302_01AA) begin
            errors++; $display("FAIL wrap_data: got %h want 030201aa", if_data);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'h13; mem[16'h0101] = 8'h05;
        mem[16'h0300] = 8'h11; mem[16'h0301] = 8'h22; mem[16'h0302] = 8'h33; mem[16'h0303] = 8'h44;
        mem[16'h0400] = 8'hDE; mem[16'h0401] = 8'hAD; mem[16'h0402] = 8'hBE; mem[16'h0403] = 8'hEF;
        mem[16'h2002] = 8'h77; mem[16'h2003] = 8'h66; mem[16'h2004] = 8'hFF;
        mem[16'hFFFF] = 8'hAA; mem[16'h0001] = 8'h01; mem[16'h0002] = 8'h02;
        mem[16'h0000] = 8'h00;
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_flush();
        test_stall();
        test_write_stall();
        test_reset_mid();
        mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h02; mem[16'h0002] = 8'h03;
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, width of all address ports.
REQ-002 SHALL have ports (name direction width meaning), clock and reset first:
  clk_in  input  1  system clock, all state on rising edge
  rst_in  input  1  reset, asynchronous, active-high
  rdy_in  input  1  1 = bus owned by CPU; 0 = stall (debug host owns bus)
  flush_in  input  1  abort in-flight instruction fetch
  if_req  input  1  fetch request, held until if_done
  if_addr  input  ADDR_W  fetch byte address
  if_done  output  1  one-cycle pulse, if_data valid
  if_data  output  32  fetched word, little-endian
  lsu_req  input  1  load/store request, held until lsu_done
  lsu_wr  input  1  1 = store, 0 = load
  lsu_len  input  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes
  lsu_addr  input  ADDR_W  load/store byte address
  lsu_wdata  input  32  store data, low bytes used
  lsu_done  output  1  one-cycle pulse, access complete
  lsu_rdata  output  32  load data, zero-extended above len
  mem_din  input  8  memory read byte
  mem_dout  output  8  memory write byte
  mem_a  output  ADDR_W  memory byte address
  mem_wr  output  1  1 = write this cycle
REQ-003 SHALL use one clock, clk_in; reset rst_in is asynchronous and active-high.

Function
REQ-004 SHALL share the single byte-wide memory port between fetch and LSU with states IDLE, READ, WRITE.
REQ-005 SHALL arbitrate only in IDLE, LSU priority over fetch, non-preemptive; accepted request latched (addr, len, wdata, owner) at the accepting edge.
REQ-006 SHALL ignore requests in the cycle its done pulse is high; re-arbitration starts the next cycle.
REQ-007 SHALL, in IDLE, drive mem_a = 0, mem_wr = 0, mem_dout = 0 (address 0 read is side-effect free; never idle on IO space).
REQ-008 SHALL assume memory read latency of one cycle: byte for mem_a issued in cycle t valid on mem_din in cycle t+1.
REQ-009 READ of n bytes accepted in cycle C0: mem_a = addr+i in cycle C(1+i), i = 0..n-1; byte i captured at end of C(2+i) into bits 8i+7:8i; done pulse in C(n+2); fetch word latency 6 cycles.
REQ-010 WRITE of n bytes accepted in C0: mem_wr = 1, mem_a = addr+i, mem_dout = wdata[8i+7:8i] in C(1+i); lsu_done in C(n+1); mem_wr = 0 in all other cycles.
REQ-011 Address arithmetic SHALL wrap modulo 2^ADDR_W; byte counter 3 bits, saturates never past n.
REQ-012 if_data/lsu_rdata SHALL hold last completed value until next completion of same owner.
REQ-013 flush_in high with fetch in flight SHALL return to IDLE next edge, suppress if_done, mem_a = 0; flush in IDLE discards nothing else; flush never affects an LSU transaction.
REQ-014 flush_in and if_req high in IDLE same cycle SHALL not accept the fetch.
REQ-015 rdy_in low SHALL freeze all state and counters and force mem_wr = 0; no capture.
REQ-016 On first rdy_in-high cycle after a stall, SHALL re-issue address of oldest uncaptured byte and capture nothing that cycle; writes resume at the unwritten byte; no byte written twice, none skipped.
REQ-017 Done pulses SHALL never be asserted while rdy_in is low; a pending pulse is deferred to the first rdy_in-high cycle.

Reset
REQ-018 rst_in high SHALL immediately force IDLE, mem_wr = 0, mem_a = 0, mem_dout = 0, if_done = lsu_done = 0, if_data = lsu_rdata = 0, counter = 0.
REQ-019 Reset mid-transaction SHALL discard it without a done pulse; first arbitration on the first edge after release.

Verification
REQ-020 Fetch 0x100, memory 13 05 00 00 -> mem_a 0x100..0x103 cycles 1-4, if_done cycle 6, if_data = 0x00000513.
REQ-021 if_req and lsu_req (load, len 00, 0x2004 = 0xFF) same cycle -> load first, lsu_rdata = 0x000000FF, lsu_done cycle 3, fetch accepted cycle 4.
REQ-022 Store len 01, 0x2000, wdata 0x0000BEEF -> cycle 1 mem_a 0x2000 dout 0xEF wr 1, cycle 2 0x2001 0xBE wr 1, lsu_done cycle 3, mem_wr 0 after.
REQ-023 flush_in in cycle 3 of fetch -> IDLE cycle 4, no if_done, if_data unchanged.
REQ-024 rdy_in low cycles 3-5 of word fetch -> mem_wr 0, byte re-issued cycle 6, if_data correct, if_done 4 cycles late.
REQ-025 rst_in asserted mid-store between edges -> mem_wr 0 immediately, no lsu_done, IDLE after release.
